// File: rtl/hilo_muldiv_if.sv
// Handshake and result bus between the EX stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(parameter int unsigned WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, cancel,
                  input  busy, done, div_by_zero, hi, lo);
  modport slave  (input  start, op, a, b, cancel,
                  output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers and MTHI/MTLO moves.
// One multiplier/quotient bit per cycle; signed ops run on magnitudes and fix the sign at the end.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hilo_muldiv_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               neg_lo;
  logic               neg_hi;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;

  logic               sgn;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quo_fin;
  logic [WIDTH-1:0]   rem_fin;

  always_comb begin
    sgn   = (bus.op == 3'd0) || (bus.op == 3'd2);
    mag_a = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    mag_b = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // acc = {partial high product, remaining multiplier bits}; shifts right each cycle
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    prod_fin = neg_lo ? -mul_next : mul_next;

    // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = rem_sh - {1'b0, opnd};
    div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    quo_fin  = neg_lo ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    rem_fin  = neg_hi ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      if (bus.cancel) begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            state  <= IDLE;
            busy_q <= 1'b0;
            if (bus.start) begin
              case (bus.op)
                3'd0, 3'd1: begin
                  state  <= MUL;
                  busy_q <= 1'b1;
                  cnt    <= '0;
                  acc    <= {{WIDTH{1'b0}}, mag_b};
                  opnd   <= mag_a;
                  neg_lo <= sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                  neg_hi <= 1'b0;
                end
                3'd2, 3'd3: begin
                  if (bus.b == '0) begin
                    state  <= DONE;
                    done_q <= 1'b1;
                    dbz_q  <= 1'b1;
                  end else begin
                    state  <= DIV;
                    busy_q <= 1'b1;
                    cnt    <= '0;
                    acc    <= {{WIDTH{1'b0}}, mag_a};
                    opnd   <= mag_b;
                    neg_lo <= sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_hi <= sgn && bus.a[WIDTH-1];
                  end
                end
                3'd4:    hi_q <= bus.a;
                3'd5:    lo_q <= bus.a;
                default: ;
              endcase
            end
          end
          MUL: begin
            acc <= mul_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              hi_q   <= prod_fin[2*WIDTH-1:WIDTH];
              lo_q   <= prod_fin[WIDTH-1:0];
            end
          end
          DIV: begin
            acc <= div_next;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              hi_q   <= rem_fin;
              lo_q   <= quo_fin;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: expected HI/LO computed with native 64-bit arithmetic.
module tb_hilo_muldiv_unit;
  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;
  exp_t sb[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  hilo_muldiv_if #(.WIDTH(32)) bus ();
  hilo_muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    longint sa, sbv;
    e.hi = m_hi; e.lo = m_lo; e.dbz = 1'b0;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      3'd0: begin p = 64'(sa * sbv); e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd2: if (b == 0) e.dbz = 1'b1;
            else begin e.lo = 32'(sa / sbv); e.hi = 32'(sa % sbv); end
      3'd3: if (b == 0) e.dbz = 1'b1;
            else begin e.lo = a / b; e.hi = a % b; end
      default: ;
    endcase
    return e;
  endfunction

  // Drives start for one edge; returns in cycle 1 after that edge with a/b scrambled.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit now, input bit push);
    exp_t e;
    if (!now) @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    if (push) begin
      e = model(op, a, b);
      sb.push_back(e);
      m_hi = e.hi; m_lo = e.lo;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom; bus.b = $urandom; bus.op = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(input int first, output int cyc, output int bcnt, output bit ok);
    cyc = first; bcnt = 0;
    while (!bus.done && cyc < 45) begin
      if (bus.busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
    ok = bus.done;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      $display("FAIL reset_hilo hi=%h lo=%h required 0/0", bus.hi, bus.lo); end else passed++;
    total++; if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
      $display("FAIL reset_flags busy/done/dbz=%b required 000", {bus.busy, bus.done, bus.div_by_zero}); end else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_arith(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b);
    int cyc, bcnt; bit ok; exp_t e; int exp_cyc;
    exp_cyc = ((op == 3'd2 || op == 3'd3) && b == 0) ? 1 : 33;
    issue(op, a, b, 1'b0, 1'b1);
    wait_done(1, cyc, bcnt, ok);
    e = sb.pop_front();
    total++; if (!ok || cyc != exp_cyc) begin
      $display("FAIL %s_latency done_seen=%0d cycle=%0d required cycle %0d", name, ok, cyc, exp_cyc); end else passed++;
    total++; if (bcnt != exp_cyc - 1 || bus.busy !== 1'b0) begin
      $display("FAIL %s_busy busy_cycles=%0d busy_at_done=%b required %0d/0", name, bcnt, bus.busy, exp_cyc - 1); end else passed++;
    total++; if (bus.hi !== e.hi || bus.lo !== e.lo || bus.div_by_zero !== e.dbz) begin
      $display("FAIL %s_result hi=%h lo=%h dbz=%b required %h %h %b", name, bus.hi, bus.lo,
               bus.div_by_zero, e.hi, e.lo, e.dbz); end else passed++;
  endtask

  task automatic test_mult;
    test_arith("mult_neg1x2", 3'd0, 32'hFFFFFFFF, 32'h00000002);
    test_arith("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    test_arith("mult_minxmin", 3'd0, 32'h80000000, 32'h80000000);
    for (int unsigned i = 0; i < 3; i++) begin
      test_arith("mult_rand", 3'(i % 2), $urandom, $urandom);
    end
  endtask

  task automatic test_div;
    test_arith("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'h2);
    test_arith("divu_7_2", 3'd3, 32'h7, 32'h2);
    test_arith("div_7_m2", 3'd2, 32'h7, 32'hFFFFFFFE);
    test_arith("div_overflow", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    test_arith("divu_small_div", 3'd3, 32'hFFFFFFFF, 32'h1);
    for (int unsigned i = 0; i < 3; i++) begin
      test_arith("div_rand", 3'(2 + i % 2), $urandom, $urandom_range(1, 32'h00FFFFFF));
    end
  endtask

  task automatic test_div_by_zero;
    test_arith("divu_by_zero", 3'd3, 32'h5, 32'h0);
    test_arith("div_by_zero", 3'd2, 32'h80000000, 32'h0);
  endtask

  task automatic test_move;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.a = 32'h12345678; m_hi = 32'h12345678;
    @(negedge clk);
    bus.op = 3'd5; bus.a = 32'h9ABCDEF0;
    total++; if (bus.hi !== m_hi || bus.lo !== m_lo || bus.done !== 1'b0) begin
      $display("FAIL mthi hi=%h lo=%h done=%b required %h %h 0", bus.hi, bus.lo, bus.done, m_hi, m_lo); end else passed++;
    m_lo = 32'h9ABCDEF0;
    @(negedge clk);
    bus.start = 1'b0;
    total++; if (bus.hi !== m_hi || bus.lo !== m_lo || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL mtlo hi=%h lo=%h done=%b busy=%b required %h %h 0 0", bus.hi, bus.lo,
               bus.done, bus.busy, m_hi, m_lo); end else passed++;
  endtask

  task automatic test_busy_ignore;
    int cyc, bcnt; bit ok; exp_t e;
    issue(3'd0, 32'h00001234, 32'hFFFF0001, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'h5; bus.b = 32'h0;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(11, cyc, bcnt, ok);
    e = sb.pop_front();
    total++; if (!ok || cyc != 33 || bcnt != 22) begin
      $display("FAIL start_while_busy done_seen=%0d cycle=%0d busy_after10=%0d required 33/22", ok, cyc, bcnt); end else passed++;
    total++; if (bus.hi !== e.hi || bus.lo !== e.lo || bus.div_by_zero !== 1'b0) begin
      $display("FAIL start_while_busy_result hi=%h lo=%h dbz=%b required %h %h 0", bus.hi, bus.lo,
               bus.div_by_zero, e.hi, e.lo); end else passed++;
  endtask

  task automatic test_cancel;
    bit saw_done;
    saw_done = 1'b0;
    issue(3'd2, 32'h00ABCDEF, 32'h00000013, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin
      $display("FAIL cancel_inflight busy=%b required 1", bus.busy); end else passed++;
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin
      $display("FAIL cancel busy=%b done=%b hi=%h lo=%h required 0 0 %h %h", bus.busy, bus.done,
               bus.hi, bus.lo, m_hi, m_lo); end else passed++;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) begin
      $display("FAIL cancel_no_done activity_after_cancel=%b required 0", saw_done); end else passed++;
  endtask

  task automatic test_async_reset;
    issue(3'd1, 32'hDEADBEEF, 32'h00000003, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      $display("FAIL async_reset hi=%h lo=%h busy=%b done=%b required 0 0 0 0", bus.hi, bus.lo,
               bus.busy, bus.done); end else passed++;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    int cyc, bcnt; bit ok; exp_t e;
    issue(3'd1, 32'h89ABCDEF, 32'h12345678, 1'b0, 1'b1);
    wait_done(1, cyc, bcnt, ok);
    e = sb.pop_front();
    total++; if (!ok || bus.hi !== e.hi || bus.lo !== e.lo) begin
      $display("FAIL b2b_first done_seen=%0d hi=%h lo=%h required %h %h", ok, bus.hi, bus.lo, e.hi, e.lo); end else passed++;
    issue(3'd1, 32'hFEDCBA98, 32'h76543210, 1'b1, 1'b1);
    wait_done(1, cyc, bcnt, ok);
    e = sb.pop_front();
    total++; if (!ok || cyc != 33 || bcnt != 32) begin
      $display("FAIL b2b_second_latency done_seen=%0d cycle=%0d busy_cycles=%0d required 33/32", ok, cyc, bcnt); end else passed++;
    total++; if (bus.hi !== e.hi || bus.lo !== e.lo) begin
      $display("FAIL b2b_second_result hi=%h lo=%h required %h %h", bus.hi, bus.lo, e.hi, e.lo); end else passed++;
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
    test_reset;
    test_mult;
    test_div;
    test_div_by_zero;
    test_move;
    test_busy_ignore;
    test_cancel;
    test_async_reset;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
